mm_engine_arbiter: RTL and testbench

- Shares one systolic matrix-multiply engine (3x3, start/done handshake) between NUM_REQ requesters, e.g. ECG feature layers issuing multiply jobs.
- Round-robin arbitration; drives the engine's one-cycle start pulse, waits for done, returns a one-cycle response to the owning requester.
- Drives an operand-select index for the external operand/result mux.
- Includes a watchdog that terminates hung jobs.

---
 rtl/mm_engine_arbiter_if.sv | 27 ++
 rtl/mm_engine_arbiter.sv | 143 ++++++++++++++
 tb/tb_mm_engine_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_engine_arbiter_if.sv
// Handshake bundle between requesters, the shared matrix-multiply engine and the arbiter.
// The slave modport is the arbiter's view; master is the requester/engine side.
interface mm_engine_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   sel;
  logic               eng_start;
  logic               eng_done;
  logic [NUM_REQ-1:0] rsp_valid;
  logic               rsp_err;
  logic               busy;
  logic               timeout_err;
  logic               clr_err;

  modport slave (
    input  req, eng_done, clr_err,
    output gnt, sel, eng_start, rsp_valid, rsp_err, busy, timeout_err
  );

  modport master (
    output req, eng_done, clr_err,
    input  gnt, sel, eng_start, rsp_valid, rsp_err, busy, timeout_err
  );
endinterface

// File: rtl/mm_engine_arbiter.sv
// Round-robin arbiter sharing one matrix-multiply engine between NUM_REQ requesters,
// with a per-job watchdog that aborts jobs whose done never arrives.
module mm_engine_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned IDX_W          = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic                clk,
  input logic                reset,
  mm_engine_arbiter_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StGrant, StStart, StWait, StResp} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               start_q, start_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic               found;
  logic [IDX_W-1:0]   pick;
  int unsigned        idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      win_q       <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      wdog_q      <= '0;
      err_q       <= 1'b0;
      gnt_q       <= '0;
      sel_q       <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      ptr_q       <= ptr_d;
      wdog_q      <= wdog_d;
      err_q       <= err_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  // First set request searching upward from the last winner, with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = pick;
          ptr_d   = pick;
          state_d = StGrant;
        end
      end
      StGrant: state_d = StStart;
      StStart: begin
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        wdog_d = wdog_q + 1'b1;
        // A done coinciding with the terminal count still counts as success.
        if (bus.eng_done) begin
          err_d   = 1'b0;
          state_d = StResp;
        end else if (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    gnt_d       = '0;
    rsp_valid_d = '0;
    sel_d       = win_d;
    start_d     = (state_d == StStart);
    busy_d      = (state_d != StIdle);
    rsp_err_d   = (state_d == StResp) && err_d;
    timeout_d   = timeout_q;
    if (state_d != StIdle) begin
      gnt_d[win_d] = 1'b1;
    end
    if (state_d == StResp) begin
      rsp_valid_d[win_d] = 1'b1;
    end
    if ((state_d == StResp) && (state_q != StResp) && err_d) begin
      timeout_d = 1'b1;
    end else if (bus.clr_err) begin
      timeout_d = 1'b0;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.sel         = sel_q;
  assign bus.eng_start   = start_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_mm_engine_arbiter.sv
// Self-checking bench: job-level reference model (round-robin pick, job latency,
// sticky timeout flag) compared cycle by cycle against the arbiter.
module tb_mm_engine_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset;

  mm_engine_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) bus ();

  mm_engine_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .IDX_W         (IDX_W),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W         (7)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   model_ptr;
  logic model_tmo;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      int k;
      k = (p + i) % int'(NUM_REQ);
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from IDLE. delay = cycles from eng_start to eng_done; > TIMEOUT means never.
  task automatic do_job(input logic [3:0] req_v, input int delay, input bit drop,
                        input bit clr_hold, input string tag);
    int         w;
    int         dc;
    int         rc;
    logic [3:0] oh;
    logic       err;
    bus.req   = req_v;
    w         = rr_pick(req_v, model_ptr);
    model_ptr = w;
    oh        = 4'(1 << w);
    err       = (delay > int'(TIMEOUT));
    dc        = 2 + delay;
    rc        = err ? int'(TIMEOUT) + 3 : dc + 1;

    step();
    checks++;
    if ({bus.gnt, bus.sel, bus.busy, bus.eng_start, bus.rsp_valid} !==
        {oh, IDX_W'(w), 1'b1, 1'b0, 4'b0}) begin
      errors++;
      $display("FAIL %s grant: gnt=%b sel=%0d busy=%b start=%b rsp=%b, want gnt=%b sel=%0d",
               tag, bus.gnt, bus.sel, bus.busy, bus.eng_start, bus.rsp_valid, oh, w);
    end

    step();
    checks++;
    if ({bus.gnt, bus.sel, bus.eng_start, bus.rsp_valid} !== {oh, IDX_W'(w), 1'b1, 4'b0}) begin
      errors++;
      $display("FAIL %s start: gnt=%b sel=%0d start=%b rsp=%b, want gnt=%b start=1",
               tag, bus.gnt, bus.sel, bus.eng_start, bus.rsp_valid, oh);
    end

    for (int c = 3; c < rc; c++) begin
      step();
      bus.eng_done = (c == dc);
      bus.clr_err  = clr_hold && (c == rc - 1);
      checks++;
      if ({bus.gnt, bus.sel, bus.busy, bus.eng_start, bus.rsp_valid} !==
          {oh, IDX_W'(w), 1'b1, 1'b0, 4'b0}) begin
        errors++;
        $display("FAIL %s wait c%0d: gnt=%b sel=%0d busy=%b start=%b rsp=%b, want gnt=%b",
                 tag, c, bus.gnt, bus.sel, bus.busy, bus.eng_start, bus.rsp_valid, oh);
      end
    end

    step();
    bus.eng_done = 1'b0;
    bus.clr_err  = 1'b0;
    if (err) model_tmo = 1'b1;
    else if (clr_hold) model_tmo = 1'b0;
    checks++;
    if ({bus.gnt, bus.sel, bus.rsp_valid, bus.rsp_err, bus.timeout_err, bus.busy} !==
        {oh, IDX_W'(w), oh, err, model_tmo, 1'b1}) begin
      errors++;
      $display("FAIL %s resp c%0d: gnt=%b rsp=%b err=%b tmo=%b busy=%b, want rsp=%b err=%b tmo=%b",
               tag, rc, bus.gnt, bus.rsp_valid, bus.rsp_err, bus.timeout_err, bus.busy,
               oh, err, model_tmo);
    end
    if (drop) bus.req = req_v & ~oh;

    step();
    checks++;
    if ({bus.gnt, bus.busy, bus.rsp_valid, bus.eng_start, bus.timeout_err} !==
        {4'b0, 1'b0, 4'b0, 1'b0, model_tmo}) begin
      errors++;
      $display("FAIL %s idle: gnt=%b busy=%b rsp=%b start=%b tmo=%b, want all 0 tmo=%b",
               tag, bus.gnt, bus.busy, bus.rsp_valid, bus.eng_start, bus.timeout_err, model_tmo);
    end
  endtask

  task automatic pulse_clr(input string tag);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    model_tmo   = 1'b0;
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL %s clr: timeout_err=%b, want 0", tag, bus.timeout_err);
    end
  endtask

  task automatic test_reset();
    bus.req      = '0;
    bus.eng_done = 1'b0;
    bus.clr_err  = 1'b0;
    reset        = 1'b1;
    model_ptr    = NUM_REQ - 1;
    model_tmo    = 1'b0;
    #1;
    checks++;
    if ({bus.gnt, bus.sel, bus.eng_start, bus.rsp_valid, bus.rsp_err, bus.busy,
         bus.timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset: gnt=%b sel=%0d start=%b rsp=%b err=%b busy=%b tmo=%b, want 0",
               bus.gnt, bus.sel, bus.eng_start, bus.rsp_valid, bus.rsp_err, bus.busy,
               bus.timeout_err);
    end
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_job();
    do_job(4'b0001, 10, 1'b1, 1'b0, "single");
  endtask

  task automatic test_round_robin();
    for (int j = 0; j < 5; j++) do_job(4'b1111, 5, 1'b0, 1'b0, "rr_all");
    bus.req = '0;
  endtask

  task automatic test_rr_pointer();
    do_job(4'b0010, 3, 1'b1, 1'b0, "ptr_a");
    do_job(4'b1010, 3, 1'b1, 1'b0, "ptr_b");
    do_job(bus.req, 3, 1'b1, 1'b0, "ptr_c");
    bus.req = '0;
  endtask

  task automatic test_timeout();
    do_job(4'b0100, 1000, 1'b1, 1'b0, "timeout");
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.timeout_err !== 1'b1) begin
        errors++;
        $display("FAIL sticky c%0d: timeout_err=%b, want 1", i, bus.timeout_err);
      end
    end
    pulse_clr("timeout");
    do_job(4'b0100, 1000, 1'b1, 1'b1, "set_wins");
    pulse_clr("set_wins");
  endtask

  task automatic test_boundary();
    do_job(4'b0001, int'(TIMEOUT), 1'b1, 1'b0, "done_terminal");
    do_job(4'b0001, int'(TIMEOUT) + 1, 1'b1, 1'b0, "done_late");
    pulse_clr("done_late");
    bus.req      = '0;
    bus.eng_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({bus.gnt, bus.busy, bus.eng_start, bus.rsp_valid} !== '0) begin
        errors++;
        $display("FAIL stray_done c%0d: gnt=%b busy=%b start=%b rsp=%b, want 0",
                 i, bus.gnt, bus.busy, bus.eng_start, bus.rsp_valid);
      end
    end
    bus.eng_done = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_job();
    bus.req   = 4'b0100;
    model_ptr = rr_pick(4'b0100, model_ptr);
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.gnt, bus.sel, bus.eng_start, bus.rsp_valid, bus.rsp_err, bus.busy,
         bus.timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid: gnt=%b sel=%0d start=%b rsp=%b busy=%b, want 0",
               bus.gnt, bus.sel, bus.eng_start, bus.rsp_valid, bus.busy);
    end
    bus.req = '0;
    step();
    reset     = 1'b0;
    model_ptr = NUM_REQ - 1;
    model_tmo = 1'b0;
    step();
    checks++;
    if ({bus.rsp_valid, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_after: rsp=%b busy=%b, want 0", bus.rsp_valid, bus.busy);
    end
    do_job(4'b0101, 4, 1'b1, 1'b0, "post_reset_a");
    do_job(bus.req, 4, 1'b1, 1'b0, "post_reset_b");
    bus.req = '0;
  endtask

  task automatic test_random();
    for (int j = 0; j < 25; j++) begin
      logic [3:0] r;
      int         d;
      r = 4'($urandom_range(1, 15));
      d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(60, 70)) :
                                        int'($urandom_range(1, 20));
      do_job(r, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
      if (model_tmo && ($urandom_range(0, 1) == 1)) pulse_clr("random");
    end
    bus.req = '0;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_rr_pointer();
    test_timeout();
    test_boundary();
    test_reset_mid_job();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
